// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: fetch port, data port, memory port and
// the per-stage stall outputs. The arbiter takes the slave side; the
// pipeline/memory environment takes the master side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;
  logic              d_req;
  logic              d_rw;
  logic              d_size;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;
  logic              m_en;
  logic              m_rw;
  logic              m_size;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;
  logic              stall_if;
  logic              stall_mem;

  modport slave (
    input  if_req, if_addr, d_req, d_rw, d_size, d_addr, d_wdata, m_rdata,
    output if_rdata, if_ready, d_rdata, d_ready,
           m_en, m_rw, m_size, m_addr, m_wdata, stall_if, stall_mem
  );

  modport master (
    output if_req, if_addr, d_req, d_rw, d_size, d_addr, d_wdata, m_rdata,
    input  if_rdata, if_ready, d_rdata, d_ready,
           m_en, m_rw, m_size, m_addr, m_wdata, stall_if, stall_mem
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port fixed-latency memory between the
// fetch (instruction) port and the data port. Data wins ties unless fetch has
// already lost MAX_STREAK grants in a row. Each access runs IDLE -> ACCESS
// (MEM_LATENCY cycles of m_en) -> RESP (one-cycle ready pulse).
// Optional: define ARB_STATS_EN to add the stat_conflicts and
// stat_starve_grants saturating counters.
module mem_port_arbiter #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1,
  parameter int MAX_STREAK  = 3
) (
  input  logic clk,
  input  logic reset,
  mem_port_arbiter_if.slave bus
`ifdef ARB_STATS_EN
  ,
  output logic [15:0] stat_conflicts,
  output logic [15:0] stat_starve_grants
`endif
);
  localparam logic [3:0] LAT_M1     = 4'(MEM_LATENCY - 1);
  localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state_q, state_d;
  logic              owner_data_q;   // 1: data port owns the access
  logic [ADDR_W-1:0] addr_q;
  logic              rw_q;
  logic              size_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        cnt_q;
  logic [3:0]        streak_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;

  logic any_req, both_req, force_fetch, take_data;

  assign any_req     = bus.if_req | bus.d_req;
  assign both_req    = bus.if_req & bus.d_req;
  assign force_fetch = both_req & (streak_q == STREAK_MAX);
  assign take_data   = bus.d_req & ~force_fetch;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: grant from IDLE, leave ACCESS when the latency counter expires
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ACCESS;
      ACCESS:  if (cnt_q == 4'd0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant capture, latency count, read-data capture and streak tracking
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_data_q <= 1'b0;
      addr_q       <= '0;
      rw_q         <= 1'b0;
      size_q       <= 1'b0;
      wdata_q      <= '0;
      cnt_q        <= 4'd0;
      streak_q     <= 4'd0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (any_req) begin
          owner_data_q <= take_data;
          addr_q       <= take_data ? bus.d_addr : bus.if_addr;
          // fetch is always a word read
          rw_q         <= take_data & bus.d_rw;
          size_q       <= take_data & bus.d_size;
          if (take_data) wdata_q <= bus.d_wdata;
          cnt_q        <= LAT_M1;
          // streak counts data wins only while fetch is actually waiting
          if (take_data && bus.if_req)
            streak_q <= (streak_q == STREAK_MAX) ? streak_q : streak_q + 4'd1;
          else
            streak_q <= 4'd0;
        end
        ACCESS: begin
          if (cnt_q == 4'd0) begin
            if (!rw_q) begin
              if (owner_data_q) d_rdata_q  <= bus.m_rdata;
              else              if_rdata_q <= bus.m_rdata;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Memory port: enables/controls only during ACCESS, address/data hold
  assign bus.m_en     = (state_q == ACCESS);
  assign bus.m_rw     = (state_q == ACCESS) & rw_q;
  assign bus.m_size   = (state_q == ACCESS) & size_q;
  assign bus.m_addr   = addr_q;
  assign bus.m_wdata  = wdata_q;

  assign bus.if_ready  = (state_q == RESP) & ~owner_data_q;
  assign bus.d_ready   = (state_q == RESP) &  owner_data_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.stall_if  = bus.if_req & ~bus.if_ready;
  assign bus.stall_mem = bus.d_req  & ~bus.d_ready;

`ifdef ARB_STATS_EN
  // Saturating counters: IDLE-cycle conflicts and streak-forced fetch grants
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_conflicts     <= 16'd0;
      stat_starve_grants <= 16'd0;
    end else if (state_q == IDLE) begin
      if (both_req && stat_conflicts != 16'hFFFF)
        stat_conflicts <= stat_conflicts + 16'd1;
      if (force_fetch && stat_starve_grants != 16'hFFFF)
        stat_starve_grants <= stat_starve_grants + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: b1/dut1 uses MEM_LATENCY=1, b3/dut3 uses
// MEM_LATENCY=3, both MAX_STREAK=3. Memory model returns a fixed pattern
// derived from the address.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter_if #(.ADDR_W(8), .DATA_W(32)) b1 ();
  mem_port_arbiter_if #(.ADDR_W(8), .DATA_W(32)) b3 ();

`ifdef ARB_STATS_EN
  logic [15:0] s1c, s1s, s3c, s3s;
`endif

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .MEM_LATENCY(1), .MAX_STREAK(3)) dut1 (
    .clk(clk), .reset(reset), .bus(b1)
`ifdef ARB_STATS_EN
    , .stat_conflicts(s1c), .stat_starve_grants(s1s)
`endif
  );

  mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .MEM_LATENCY(3), .MAX_STREAK(3)) dut3 (
    .clk(clk), .reset(reset), .bus(b3)
`ifdef ARB_STATS_EN
    , .stat_conflicts(s3c), .stat_starve_grants(s3s)
`endif
  );

  function automatic logic [31:0] mem_f(input logic [7:0] a);
    return (a == 8'h04) ? 32'hE2811001 : {16'hC0DE, 8'h00, a};
  endfunction

  assign b1.m_rdata = mem_f(b1.m_addr);
  assign b3.m_rdata = mem_f(b3.m_addr);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Continuous properties: exclusive ready pulses and stall definition
  always @(negedge clk) begin
    if (!reset) begin
      chk("excl_ready_b1", 32'(b1.if_ready & b1.d_ready), 32'd0);
      chk("excl_ready_b3", 32'(b3.if_ready & b3.d_ready), 32'd0);
      chk("stall_if_b1", 32'(b1.stall_if), 32'(b1.if_req & ~b1.if_ready));
      chk("stall_mem_b1", 32'(b1.stall_mem), 32'(b1.d_req & ~b1.d_ready));
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, checks %0d", checks);
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        is_data;
    logic        rw;
    logic        size;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs [7];
  logic [31:0] sb_if [$];
  logic [31:0] sb_d  [$];
  logic        sb_own [$];

  // One isolated transaction on dut1, checked against its table record
  task automatic run_vec(input vec_t v);
    int n, en;
    bit got;
    logic [31:0] exp;
    @(posedge clk); #1;
    if (v.is_data) begin
      b1.d_req = 1'b1; b1.d_rw = v.rw; b1.d_size = v.size;
      b1.d_addr = v.addr; b1.d_wdata = v.wdata;
      sb_d.push_back(v.exp_rdata);
    end else begin
      b1.if_req = 1'b1; b1.if_addr = v.addr;
      sb_if.push_back(v.exp_rdata);
    end
    n = 0; en = 0; got = 0;
    @(negedge clk);
    while (!got && n < 20) begin
      if (b1.m_en) begin
        en++;
        chk("vec_m_addr", b1.m_addr, v.addr);
        chk("vec_m_rw", b1.m_rw, v.is_data & v.rw);
        chk("vec_m_size", b1.m_size, v.is_data & v.size);
        if (v.is_data && v.rw) chk("vec_m_wdata", b1.m_wdata, v.wdata);
      end
      if (v.is_data ? b1.d_ready : b1.if_ready) got = 1;
      else begin @(negedge clk); n++; end
    end
    chk("vec_ready_seen", got, 1);
    chk("vec_latency", n, v.exp_lat);
    chk("vec_en_cycles", en, 1);
    if (got) begin
      chk("vec_resp_m_en", b1.m_en, 0);
      if (v.is_data) begin exp = sb_d.pop_front();  chk("vec_d_rdata", b1.d_rdata, exp); end
      else           begin exp = sb_if.pop_front(); chk("vec_if_rdata", b1.if_rdata, exp); end
    end
    @(posedge clk); #1;
    b1.if_req = 1'b0; b1.d_req = 1'b0;
    @(negedge clk);
    chk("vec_pulse_one_cycle", {b1.if_ready, b1.d_ready}, 0);
  endtask

  initial begin
    int cyc, td, tf, en, nr, last;
    bit got;
    logic e;

    b1.if_req = 0; b1.if_addr = '0; b1.d_req = 0; b1.d_rw = 0; b1.d_size = 0;
    b1.d_addr = '0; b1.d_wdata = '0;
    b3.if_req = 0; b3.if_addr = '0; b3.d_req = 0; b3.d_rw = 0; b3.d_size = 0;
    b3.d_addr = '0; b3.d_wdata = '0;

    //              data  rw    size  addr   wdata         exp_rdata     lat
    vecs[0] = '{1'b0, 1'b0, 1'b0, 8'h04, 32'h0,        32'hE2811001, 2};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 8'h20, 32'h0,        32'hC0DE0020, 2};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 8'h30, 32'h12345678, 32'hC0DE0020, 2};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 8'hFC, 32'h0,        32'hC0DE00FC, 2};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 8'h00, 32'h0,        32'hC0DE0000, 2};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 8'hFF, 32'hDEADBEEF, 32'hC0DE0000, 2};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 8'h08, 32'h0,        32'hC0DE0008, 2};

    // Reset state
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_b1_ctl", {b1.m_en, b1.m_rw, b1.m_size, b1.if_ready, b1.d_ready}, 0);
    chk("rst_b1_addr", b1.m_addr, 0);
    chk("rst_b1_wdata", b1.m_wdata, 0);
    chk("rst_b1_rdata", b1.if_rdata | b1.d_rdata, 0);
    chk("rst_b3_ctl", {b3.m_en, b3.m_rw, b3.m_size, b3.if_ready, b3.d_ready}, 0);
`ifdef ARB_STATS_EN
    chk("rst_stats", {s1c, s1s}, 0);
`endif
    @(posedge clk); #1 reset = 1'b0;

    // Idle for 20 cycles
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_b1", {b1.m_en, b1.if_ready, b1.d_ready, b1.stall_if, b1.stall_mem}, 0);
      chk("idle_b3", {b3.m_en, b3.if_ready, b3.d_ready, b3.stall_if, b3.stall_mem}, 0);
    end

    // Table of isolated single-port transactions
    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Simultaneous requests: data first, fetch L+2 cycles after d_ready
    @(posedge clk); #1;
    b1.if_req = 1; b1.if_addr = 8'h40;
    b1.d_req = 1; b1.d_rw = 0; b1.d_size = 0; b1.d_addr = 8'h44;
    cyc = 0; td = -1; tf = -1;
    while (tf < 0 && cyc < 30) begin
      @(negedge clk);
      if (cyc == 2) chk("conc_stall_if_waiting", b1.stall_if, 1);
      if (b1.d_ready && td < 0) begin td = cyc; chk("conc_d_rdata", b1.d_rdata, 32'hC0DE0044); end
      if (b1.if_ready && tf < 0) begin tf = cyc; chk("conc_if_rdata", b1.if_rdata, 32'hC0DE0040); end
      @(posedge clk); #1;
      if (td == cyc) b1.d_req = 0;
      if (tf == cyc) b1.if_req = 0;
      cyc++;
    end
    b1.if_req = 0; b1.d_req = 0;
    chk("conc_d_first", td, 2);
    chk("conc_f_after", tf - td, 3);

    // L=3 byte write: controls held 3 cycles, late address change ignored
    @(posedge clk); #1;
    b3.d_req = 1; b3.d_rw = 1; b3.d_size = 1; b3.d_addr = 8'h10; b3.d_wdata = 32'h000000AA;
    cyc = 0; en = 0; got = 0;
    while (!got && cyc < 30) begin
      @(negedge clk);
      if (b3.m_en) begin
        en++;
        chk("l3_m_ctl", {b3.m_rw, b3.m_size}, 2'b11);
        chk("l3_m_addr", b3.m_addr, 8'h10);
        chk("l3_m_wdata", b3.m_wdata, 32'h000000AA);
      end
      if (b3.d_ready) got = 1;
      else begin
        @(posedge clk); #1;
        if (cyc == 1) begin b3.d_addr = 8'h55; b3.d_wdata = 32'h0; end
        cyc++;
      end
    end
    chk("l3_latency", cyc, 4);
    chk("l3_en_cycles", en, 3);
    chk("l3_d_rdata_kept", b3.d_rdata, 0);
    chk("l3_resp_ctl", {b3.m_en, b3.m_rw, b3.m_size}, 0);
    chk("l3_resp_addr_hold", b3.m_addr, 8'h10);
    @(posedge clk); #1; b3.d_req = 0;

    // Reset in the middle of an L=3 read; access restarts afterwards
    @(posedge clk); #1;
    b3.d_req = 1; b3.d_rw = 0; b3.d_size = 0; b3.d_addr = 8'h70;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_ctl", {b3.m_en, b3.d_ready}, 0);
    chk("mid_rst_addr", b3.m_addr, 0);
    @(posedge clk); #1;
    chk("mid_rst_after_edge", {b3.m_en, b3.d_ready}, 0);
    reset = 1'b0;
    cyc = 0; got = 0;
    @(negedge clk);
    while (!got && cyc < 30) begin
      if (b3.d_ready) got = 1;
      else begin @(negedge clk); cyc++; end
    end
    chk("restart_latency", cyc, 4);
    chk("restart_d_rdata", b3.d_rdata, 32'hC0DE0070);
    @(posedge clk); #1; b3.d_req = 0;

    // Starvation limiter: fetch held, data back-to-back
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sb_own.push_back(1); sb_own.push_back(1); sb_own.push_back(1); sb_own.push_back(0);
    end
    b1.if_req = 1; b1.if_addr = 8'h50;
    b1.d_req = 1; b1.d_rw = 0; b1.d_size = 0; b1.d_addr = 8'h60;
    cyc = 0; nr = 0; last = -1;
    while (nr < 8 && cyc < 60) begin
      @(negedge clk);
      if (b1.if_ready || b1.d_ready) begin
        e = sb_own.pop_front();
        chk("streak_owner", b1.d_ready, e);
        if (b1.d_ready) chk("streak_d_rdata", b1.d_rdata, 32'hC0DE0060);
        else            chk("streak_if_rdata", b1.if_rdata, 32'hC0DE0050);
        if (last >= 0) chk("grant_spacing", cyc - last, 3);
        last = cyc; nr++;
      end
      @(posedge clk); #1;
      cyc++;
      if (nr == 8) begin b1.if_req = 0; b1.d_req = 0; end
    end
    b1.if_req = 0; b1.d_req = 0;
    chk("streak_count", nr, 8);
    @(negedge clk);
`ifdef ARB_STATS_EN
    chk("stat_conflicts", s1c, 8);
    chk("stat_starve_grants", s1s, 2);
`endif
    chk("final_idle", {b1.m_en, b1.if_ready, b1.d_ready}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
